// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared definitions for the programmable sequence detector:
//               FSM state encodings and default sizing values.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int SEQ_MAX_LEN_DEF = 8;   // default maximum pattern length
    localparam int SEQ_CNT_W_DEF   = 16;  // default match counter width

    // 2'b11 is not a named state; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HIT  = 2'b10
    } state_t;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_sat_cnt
// Description : Saturating up-counter. Clear has priority over increment;
//               the count holds at all-ones once reached.
// Ports       : clk    - clock, rising edge
//               rst    - synchronous reset, active low
//               i_clr  - clear count to zero
//               i_inc  - increment by one unless saturated
//               o_cnt  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_sat;

    assign w_sat = (r_cnt == {CNT_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_sat) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule : seq_det_sat_cnt
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog
// Description : Programmable serial bit-sequence detector (1..MAX_LEN bits),
//               overlapping or non-overlapping, with registered one-cycle
//               match pulse and saturating match counter.
// Ports       : clk        - clock, rising edge
//               rst        - synchronous reset, active low (clears config too)
//               cfg_load   - latch pattern/pat_len/overlap_en, clear history
//               pattern    - pattern bits, pattern[pat_len-1] received first
//               pat_len    - pattern length (0 disables, >MAX_LEN saturates)
//               overlap_en - 1 = overlapping detection
//               din_valid  - din qualifier
//               din        - serial data bit
//               dout       - one-cycle match pulse
//               match_cnt  - saturating match count
//               state      - FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = SEQ_MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1),
    parameter int CNT_W   = SEQ_CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap_en,
    input  logic               din_valid,
    input  logic               din,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [1:0]         state
);

    localparam logic [LEN_W-1:0] c_MAX_LEN   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W:0]   c_MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);

    state_t             r_state;
    logic               r_dout;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_ovl;

    logic               w_active;
    logic [MAX_LEN-1:0] w_hist_next;
    logic [LEN_W:0]     w_fill_inc;    // one bit wider so fill+1 cannot wrap
    logic [LEN_W-1:0]   w_fill_next;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_len_sat;
    logic               w_match;
    logic               w_inc;
    logic               w_clr;

    assign w_active    = (r_state == ST_RUN) || (r_state == ST_HIT);
    assign w_hist_next = {r_hist[MAX_LEN-2:0], din};
    assign w_fill_inc  = {1'b0, r_fill} + (LEN_W + 1)'(1);
    assign w_fill_next = (w_fill_inc > c_MAX_LEN_X) ? c_MAX_LEN : w_fill_inc[LEN_W-1:0];
    assign w_len_sat   = (pat_len > c_MAX_LEN) ? c_MAX_LEN : pat_len;

    // Select the low r_len bits of history and pattern for comparison.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // The fill check keeps stale zeros from completing a pattern that
    // contains leading zeros before enough real bits have arrived.
    assign w_match = (r_len != '0)
                  && (w_fill_inc >= {1'b0, r_len})
                  && ((w_hist_next & w_mask) == (r_pattern & w_mask));

    assign w_inc = w_active && !cfg_load && din_valid && w_match;
    assign w_clr = w_active && cfg_load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_dout    <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_pattern <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                    r_dout  <= 1'b0;
                end
                ST_RUN, ST_HIT: begin
                    if (cfg_load) begin
                        r_pattern <= pattern;
                        r_len     <= w_len_sat;
                        r_ovl     <= overlap_en;
                        r_hist    <= '0;
                        r_fill    <= '0;
                        r_dout    <= 1'b0;
                        r_state   <= ST_RUN;
                    end else if (din_valid) begin
                        if (w_match) begin
                            r_dout  <= 1'b1;
                            r_state <= ST_HIT;
                            // Non-overlapping: discard every bit of the match.
                            if (r_ovl) begin
                                r_hist <= w_hist_next;
                                r_fill <= w_fill_next;
                            end else begin
                                r_hist <= '0;
                                r_fill <= '0;
                            end
                        end else begin
                            r_dout  <= 1'b0;
                            r_state <= ST_RUN;
                            r_hist  <= w_hist_next;
                            r_fill  <= w_fill_next;
                        end
                    end else begin
                        r_dout  <= 1'b0;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_dout  <= 1'b0;
                end
            endcase
        end
    end

    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_inc (w_inc),
        .o_cnt (match_cnt)
    );

    assign dout  = r_dout;
    assign state = r_state;

endmodule : seq_det_prog
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_prog
// Description : Scoreboard bench for seq_det_prog. Two instances share the
//               stimulus: a 16-bit counter one and a 2-bit counter one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_load;
    logic [7:0]  pattern;
    logic [3:0]  pat_len;
    logic        overlap_en;
    logic        din_valid;
    logic        din;

    logic        dout;
    logic [15:0] match_cnt;
    logic [1:0]  state;
    logic        dout_s;
    logic [1:0]  cnt_s;
    logic [1:0]  state_s;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_cnt = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t q[$];

    seq_det_prog #(.MAX_LEN(8), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap_en(overlap_en), .din_valid(din_valid),
        .din(din), .dout(dout), .match_cnt(match_cnt), .state(state)
    );

    seq_det_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut_s (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap_en(overlap_en), .din_valid(din_valid),
        .din(din), .dout(dout_s), .match_cnt(cnt_s), .state(state_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse from either instance must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (dout === 1'b1 || dout_s === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got dout=%0b/%0b expected none (cyc %0d)",
                         dout, dout_s, cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("dout", int'(dout), 1);
                chk("dout_small", int'(dout_s), 1);
                chk("cnt_at_pulse", int'(match_cnt), e.cnt);
                chk("cnt_small_at_pulse", int'(cnt_s), sat3(e.cnt));
                chk("state_hit", int'(state), 2);
                chk("state_hit_small", int'(state_s), 2);
            end
        end
    end

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
        @(negedge clk);
        cfg_load   = 1'b1;
        pattern    = p;
        pat_len    = l;
        overlap_en = o;
        din_valid  = 1'b1;   // must be discarded in favour of cfg_load
        din        = 1'b1;
        exp_cnt    = 0;
    endtask

    // Vectors are read left to right: bit n-1 is applied first.
    task automatic run_seq(input int n, input logic [15:0] d,
                           input logic [15:0] v, input logic [15:0] h);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cfg_load  = 1'b0;
            din_valid = v[n-1-i];
            din       = d[n-1-i];
            if (h[n-1-i]) begin
                exp_cnt++;
                q.push_back('{cyc + 1, exp_cnt});
            end
        end
    endtask

    task automatic end_check(input string name);
        @(negedge clk);
        cfg_load  = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        chk({name, "_missing_pulses"}, q.size(), 0);
        chk({name, "_cnt"}, int'(match_cnt), exp_cnt);
        chk({name, "_cnt_small"}, int'(cnt_s), sat3(exp_cnt));
        q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_load = 1'b0; pattern = '0; pat_len = '0;
        overlap_en = 1'b0; din_valid = 1'b1; din = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_cnt", int'(match_cnt), 0);
        chk("reset_state", int'(state), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("run_after_reset", int'(state), 1);
        // Detector is disabled until configured.
        run_seq(4, 16'hF, 16'hF, 16'h0);
        end_check("unconfigured");

        cfg(8'b111, 4'd3, 1'b0);
        run_seq(7, 16'b1111111, 16'b1111111, 16'b0010010);
        end_check("t1_nonovl");

        cfg(8'b111, 4'd3, 1'b1);
        run_seq(7, 16'b1111111, 16'b1111111, 16'b0011111);
        end_check("t2_ovl");

        cfg(8'b1011, 4'd4, 1'b1);
        run_seq(7, 16'b1011011, 16'b1111111, 16'b0001001);
        end_check("t3_ovl");

        cfg(8'b1011, 4'd4, 1'b0);
        run_seq(7, 16'b1011011, 16'b1111111, 16'b0001000);
        end_check("t3_nonovl");

        cfg(8'b111, 4'd3, 1'b0);
        run_seq(6, 16'b111111, 16'b110001, 16'b000001);
        end_check("t4_gap");

        cfg(8'b1, 4'd1, 1'b0);
        run_seq(4, 16'b1011, 16'b1111, 16'b1011);
        end_check("len1");

        // pat_len 15 saturates to 8.
        cfg(8'hFF, 4'd15, 1'b1);
        run_seq(9, 16'h1FF, 16'h1FF, 16'b000000011);
        end_check("len_sat");

        cfg(8'b111, 4'd3, 1'b1);
        run_seq(12, 16'hFFF, 16'hFFF, 16'h3FF);
        end_check("t5_saturate");
        cfg(8'b111, 4'd3, 1'b1);
        end_check("t5_clear");

        cfg(8'b111, 4'd3, 1'b0);
        run_seq(2, 16'b11, 16'b11, 16'b00);
        @(negedge clk);
        rst = 1'b0; cfg_load = 1'b1; din_valid = 1'b1; din = 1'b1;
        @(negedge clk);
        chk("t6_rst_dout", int'(dout), 0);
        chk("t6_rst_cnt", int'(match_cnt), 0);
        chk("t6_rst_state", int'(state), 0);
        rst = 1'b1; cfg_load = 1'b0;
        @(negedge clk);
        chk("t6_run_state", int'(state), 1);
        exp_cnt = 0;
        run_seq(6, 16'h3F, 16'h3F, 16'h0);
        end_check("t6_disabled");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_det_prog
`default_nettype wire
